// File: rtl/ksa_shuffler.sv
// RC4 key-scheduling: fills the S RAM with the identity permutation, then runs the KSA shuffle.
// Latency: 2**RAM_LENGTH INIT cycles + 5 cycles per index, then a one-cycle 'finished' pulse.
// No backpressure: owns the S RAM from accepted start until 'finished'; start edges while busy are dropped.
module ksa_shuffler #(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_LENGTH = 8,
  parameter int KEY_WIDTH  = 24,
  parameter int KEY_LENGTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_WIDTH-1:0]  secretKey,
  input  logic [RAM_WIDTH-1:0]  sOut,
  output logic [RAM_WIDTH-1:0]  sIn,
  output logic [RAM_LENGTH-1:0] sAddr,
  output logic                  sWren,
  output logic                  busy,
  output logic                  finished
);

  localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RD_I,
    LAT_SI,
    LAT_SJ,
    WR_I,
    WR_J,
    DONE
  } state_t;

  state_t                state;
  logic [RAM_LENGTH-1:0] i;
  logic [RAM_WIDTH-1:0]  j;
  logic [RAM_WIDTH-1:0]  si;
  logic [RAM_WIDTH-1:0]  sj;
  logic [KIDX_W-1:0]     k_idx;
  logic [KEY_WIDTH-1:0]  key_reg;
  logic                  start_q;
  logic [RAM_WIDTH-1:0]  key_byte;
  logic [RAM_WIDTH-1:0]  j_new;

  // Select the current key byte; byte 0 is the most significant byte of the latched key.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      if (k_idx == KIDX_W'(k)) begin
        key_byte = key_reg[KEY_WIDTH-1-8*k -: 8];
      end
    end
  end

  // Next j, valid in LAT_SI when sOut carries S[i]; wraps modulo the data width.
  assign j_new = j + sOut + key_byte;

  // Control FSM: start edge detect, INIT sweep and the per-index read/read/write/write swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      k_idx   <= '0;
      key_reg <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start && !start_q) begin
            key_reg <= secretKey;
            i       <= '0;
            state   <= INIT;
          end
        end
        INIT: begin
          if (&i) begin
            i     <= '0;
            j     <= '0;
            k_idx <= '0;
            state <= RD_I;
          end else begin
            i <= i + RAM_LENGTH'(1);
          end
        end
        RD_I: begin
          state <= LAT_SI;
        end
        LAT_SI: begin
          si    <= sOut;
          j     <= j_new;
          state <= LAT_SJ;
        end
        LAT_SJ: begin
          sj    <= sOut;
          state <= WR_I;
        end
        WR_I: begin
          state <= WR_J;
        end
        WR_J: begin
          if (&i) begin
            state <= DONE;
          end else begin
            i     <= i + RAM_LENGTH'(1);
            k_idx <= (k_idx == KIDX_W'(KEY_LENGTH - 1)) ? '0 : k_idx + KIDX_W'(1);
            state <= RD_I;
          end
        end
        DONE: begin
          i     <= '0;
          j     <= '0;
          k_idx <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port and status decode; write enable depends on state only, never on start or sOut.
  always_comb begin
    sAddr    = '0;
    sIn      = '0;
    sWren    = 1'b0;
    busy     = 1'b0;
    finished = 1'b0;
    case (state)
      INIT: begin
        sAddr = i;
        sIn   = RAM_WIDTH'(i);
        sWren = 1'b1;
        busy  = 1'b1;
      end
      RD_I: begin
        sAddr = i;
        busy  = 1'b1;
      end
      LAT_SI: begin
        sAddr = RAM_LENGTH'(j_new);
        busy  = 1'b1;
      end
      LAT_SJ: begin
        sAddr = RAM_LENGTH'(j);
        busy  = 1'b1;
      end
      WR_I: begin
        sAddr = i;
        sIn   = sj;
        sWren = 1'b1;
        busy  = 1'b1;
      end
      WR_J: begin
        sAddr = RAM_LENGTH'(j);
        sIn   = si;
        sWren = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        finished = 1'b1;
      end
      default: begin
        sAddr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ksa_shuffler.sv
// Bench for ksa_shuffler: software RC4 KSA model, S RAM model and a per-cycle output checker.
// Latency: checks the full INIT + KSA timeline of each run against cycle numbers counted from INIT start.
// Backpressure: none; the bench drives start/reset directly and owns the RAM model.
module tb_ksa_shuffler;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] secretKey;
  logic [7:0]  sOut;
  logic [7:0]  sIn;
  logic [7:0]  sAddr;
  logic        sWren;
  logic        busy;
  logic        finished;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ram [256];
  logic [7:0]  model_s [256];
  logic [15:0] exp_w [768];
  int          exp_n = 0;
  int          wr_ptr = 0;
  logic        mon_en = 1'b0;
  int          mon_cyc = 0;
  int          fin_count = 0;
  int          fc;

  ksa_shuffler #(
    .RAM_WIDTH (8),
    .RAM_LENGTH(8),
    .KEY_WIDTH (24),
    .KEY_LENGTH(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .secretKey(secretKey),
    .sOut     (sOut),
    .sIn      (sIn),
    .sAddr    (sAddr),
    .sWren    (sWren),
    .busy     (busy),
    .finished (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read S RAM: address in cycle N, data in cycle N+1.
  always @(posedge clk) begin
    if (sWren) ram[sAddr] <= sIn;
    sOut <= ram[sAddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Software RC4 KSA; records the expected write trace (addr,data) and the final S image.
  task automatic build_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] jj, a, b, kb;
    exp_n = 0;
    for (int n = 0; n < 256; n++) begin
      s[n] = 8'(n);
      exp_w[exp_n] = {8'(n), 8'(n)};
      exp_n++;
    end
    jj = 8'h00;
    for (int n = 0; n < 256; n++) begin
      kb = 8'(key >> (8 * (2 - (n % 3))));
      jj = jj + s[n] + kb;
      a = s[n];
      b = s[jj];
      exp_w[exp_n] = {8'(n), b};
      exp_n++;
      exp_w[exp_n] = {jj, a};
      exp_n++;
      s[n]  = b;
      s[jj] = a;
    end
    for (int n = 0; n < 256; n++) model_s[n] = s[n];
  endtask

  // Per-cycle checker: busy/finished/sWren timing and every write against the model trace.
  initial begin
    logic        exp_busy, exp_fin, exp_wr;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (finished) fin_count++;
      if (mon_en) begin
        if (mon_cyc >= 0) begin
          exp_busy = (mon_cyc <= 1535);
          exp_fin  = (mon_cyc == 1536);
          exp_wr   = (mon_cyc <= 255) ||
                     (mon_cyc <= 1535 && ((mon_cyc - 256) % 5) >= 3);
          chk($sformatf("busy@%0d", mon_cyc), busy, exp_busy);
          chk($sformatf("finished@%0d", mon_cyc), finished, exp_fin);
          chk($sformatf("sWren@%0d", mon_cyc), sWren, exp_wr);
          if (exp_wr) begin
            w = (wr_ptr < exp_n) ? exp_w[wr_ptr] : 16'hxxxx;
            wr_ptr++;
            chk($sformatf("sAddr@%0d", mon_cyc), sAddr, w[15:8]);
            chk($sformatf("sIn@%0d", mon_cyc), sIn, w[7:0]);
          end
          if (mon_cyc == 1536) begin
            chk("write count", wr_ptr, exp_n);
            mon_en = 1'b0;
          end
        end else begin
          chk("busy before INIT", busy, 1'b0);
        end
        mon_cyc++;
      end
    end
  end

  // Present a start edge with the given key; optionally keep start high afterwards.
  task automatic start_run(input logic [23:0] key, input bit hold);
    @(posedge clk);
    #1;
    build_model(key);
    secretKey = key;
    start     = 1'b1;
    wr_ptr    = 0;
    mon_cyc   = -1;
    mon_en    = 1'b1;
    if (!hold) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 2100 && mon_en; n++) @(posedge clk);
    #1;
    chk("run completes", mon_en, 1'b0);
  endtask

  task automatic check_ram(input string tag);
    for (int n = 0; n < 256; n++) chk($sformatf("%s ram[%0d]", tag, n), ram[n], model_s[n]);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    secretKey = 24'h000000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset sWren", sWren, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset finished", finished, 1'b0);
    chk("reset sAddr", sAddr, 8'h00);
    chk("reset sIn", sIn, 8'h00);
    reset = 1'b0;

    // Pin the model with hand-derived trace entries.
    build_model(24'h000000);
    chk("pin k0 i0 wr_i", exp_w[256], 16'h0000);
    chk("pin k0 i0 wr_j", exp_w[257], 16'h0000);
    chk("pin k0 i1 wr_i", exp_w[258], 16'h0101);
    chk("pin k0 i1 wr_j", exp_w[259], 16'h0101);
    chk("pin k0 i2 wr_i", exp_w[260], 16'h0203);
    chk("pin k0 i2 wr_j", exp_w[261], 16'h0302);
    chk("pin init 17", exp_w[17], 16'h1111);
    build_model(24'h1E4600);
    chk("pin k1 i0 wr_i", exp_w[256], 16'h001E);
    chk("pin k1 i0 wr_j", exp_w[257], 16'h1E00);
    chk("pin k1 i1 wr_i", exp_w[258], 16'h0165);
    chk("pin k1 i1 wr_j", exp_w[259], 16'h6501);

    // Golden runs.
    fc = fin_count;
    start_run(24'h000000, 1'b0);
    wait_done();
    chk("k0 one finished", fin_count - fc, 1);
    check_ram("k0");

    fc = fin_count;
    start_run(24'h1E4600, 1'b0);
    wait_done();
    chk("k1 one finished", fin_count - fc, 1);
    check_ram("k1");

    // Key FFFFFF, plus a start edge landing in the DONE cycle.
    fc = fin_count;
    start_run(24'hFFFFFF, 1'b0);
    repeat (1536) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("kF run completes", mon_en, 1'b0);
    chk("DONE edge dropped busy", busy, 1'b0);
    chk("kF one finished", fin_count - fc, 1);
    check_ram("kF");

    // Key change mid-run and a start edge while busy are both ignored.
    start_run(24'h1E4600, 1'b0);
    repeat (299) @(posedge clk);
    #1;
    secretKey = 24'hFFFFFF;
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    check_ram("latch");

    // Reset mid-run.
    fc = fin_count;
    start_run(24'h000000, 1'b0);
    repeat (699) @(posedge clk);
    #1;
    chk("busy before mid reset", busy, 1'b1);
    reset  = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    chk("mid reset sWren", sWren, 1'b0);
    chk("mid reset busy", busy, 1'b0);
    chk("mid reset finished", finished, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (1700) @(posedge clk);
    #1;
    chk("no finished after reset", fin_count - fc, 0);
    fc = fin_count;
    start_run(24'h000000, 1'b0);
    wait_done();
    chk("rerun one finished", fin_count - fc, 1);
    check_ram("rerun");

    // Start held high for 3000 cycles yields exactly one run.
    fc = fin_count;
    start_run(24'h1E4600, 1'b1);
    wait_done();
    repeat (1450) @(posedge clk);
    #1;
    chk("held start busy", busy, 1'b0);
    start = 1'b0;
    chk("held start one finished", fin_count - fc, 1);
    check_ram("held");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
